// File: rtl/adc_spi_pkg.sv
// Shared types and defaults for the TLC549-style serial ADC sampler.
package adc_spi_pkg;

  localparam int unsigned ADC_DATA_W      = 8;
  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_CS_SETUP    = 3;
  localparam int unsigned DEF_CONV_CYCLES = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_CONV
  } state_t;

endpackage

// File: rtl/adc_spi_sampler_if.sv
// ADC pin bundle plus the sample output stream of the sampler.
interface adc_spi_sampler_if;
  import adc_spi_pkg::*;

  logic                  en;
  logic                  adc_cs_n;
  logic                  adc_sclk;
  logic                  adc_sdo;
  logic [ADC_DATA_W-1:0] sample_data;
  logic                  sample_valid;
  logic                  busy;

  modport master (
    input  en, adc_sdo,
    output adc_cs_n, adc_sclk, sample_data, sample_valid, busy
  );

  modport slave (
    output en, adc_sdo,
    input  adc_cs_n, adc_sclk, sample_data, sample_valid, busy
  );

endinterface

// File: rtl/adc_bit_timer.sv
// SCLK phase generator: CLK_DIV clk cycles low, then CLK_DIV high, repeated while run=1.
module adc_bit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick,
  output logic bit_done
);

  logic [7:0] div_cnt;
  logic       phase;
  logic       half_end;

  assign half_end = run && (div_cnt == 8'(CLK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Ticks are high in the cycle whose closing edge flips sclk.
  assign sclk      = phase;
  assign rise_tick = half_end && !phase;
  assign fall_tick = half_end && phase;
  assign bit_done  = fall_tick;

endmodule

// File: rtl/adc_spi_sampler.sv
// Serial 8-bit ADC frame sequencer with sample strobe output.
// Optional macro ADC_SDO_SYNC_EN adds a 2-flop synchronizer on adc_sdo (needs CLK_DIV>=3).
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned CS_SETUP    = DEF_CS_SETUP,
  parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  adc_spi_sampler_if.master bus
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("adc_spi_sampler: CLK_DIV must be 2..255");
  end
  if (CS_SETUP < 1 || CS_SETUP > 255) begin : g_bad_cs_setup
    $error("adc_spi_sampler: CS_SETUP must be 1..255");
  end
  if (CONV_CYCLES < 1 || CONV_CYCLES > 65535) begin : g_bad_conv
    $error("adc_spi_sampler: CONV_CYCLES must be 1..65535");
  end

  state_t                state, next_state;
  logic [15:0]           wait_cnt;
  logic [2:0]            bit_cnt;
  logic [ADC_DATA_W-1:0] shreg, data_q;
  logic                  cs_n_q, valid_q, busy_q;
  logic                  sclk, rise_tick, fall_tick, bit_done;
  logic                  capture, sdo_cap;

  adc_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state == ST_SHIFT),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .bit_done  (bit_done)
  );

`ifdef ADC_SDO_SYNC_EN
  if (CLK_DIV < 3) begin : g_sync_needs_div3
    $error("adc_spi_sampler: ADC_SDO_SYNC_EN requires CLK_DIV >= 3");
  end

  logic [1:0] sdo_sync;
  logic [1:0] rise_pipe;

  // The capture strobe is delayed to match the synchronizer, landing inside the high half.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_sync  <= '0;
      rise_pipe <= '0;
    end else begin
      sdo_sync  <= {sdo_sync[0], bus.adc_sdo};
      rise_pipe <= {rise_pipe[0], rise_tick};
    end
  end

  assign capture = rise_pipe[1];
  assign sdo_cap = sdo_sync[1];
`else
  assign capture = rise_tick;
  assign sdo_cap = bus.adc_sdo;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (bus.en) next_state = ST_SETUP;
      ST_SETUP: if (wait_cnt == 16'(CS_SETUP - 1)) next_state = ST_SHIFT;
      ST_SHIFT: if (bit_done && bit_cnt == 3'd7) next_state = ST_CONV;
      ST_CONV:  if (wait_cnt == 16'(CONV_CYCLES - 1)) next_state = bus.en ? ST_SETUP : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || next_state != state) begin
      wait_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == ST_SETUP || state == ST_CONV) wait_cnt <= wait_cnt + 16'd1;
      if (fall_tick) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg <= '0;
    else if (capture) shreg <= {shreg[ADC_DATA_W-2:0], sdo_cap};
  end

  // Pin and status outputs are registered from next_state so they change glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      cs_n_q  <= !(next_state == ST_SETUP || next_state == ST_SHIFT);
      busy_q  <= (next_state != ST_IDLE);
      valid_q <= (state == ST_SHIFT) && (next_state == ST_CONV);
      if (state == ST_SHIFT && next_state == ST_CONV) data_q <= shreg;
    end
  end

  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sclk     = sclk;
  assign bus.sample_data  = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;

endmodule
